// File: rtl/and_unit_rr_arbiter_if.sv
// Requester/consumer bundle for and_unit_rr_arbiter.
// Defining AND_ARB_OPSEL_EN adds the op_in/out_op operation-select signals.
interface and_unit_rr_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] a_in;
  logic [NUM_REQ*WIDTH-1:0] b_in;
  logic [NUM_REQ-1:0]       gnt;
  logic                     out_valid;
  logic                     out_ready;
  logic [IDW-1:0]           out_id;
  logic [WIDTH-1:0]         out_data;

`ifdef AND_ARB_OPSEL_EN
  logic [NUM_REQ*2-1:0]     op_in;
  logic [1:0]               out_op;

  modport master (
    output req, a_in, b_in, out_ready, op_in,
    input  gnt, out_valid, out_id, out_data, out_op
  );

  modport slave (
    input  req, a_in, b_in, out_ready, op_in,
    output gnt, out_valid, out_id, out_data, out_op
  );
`else
  modport master (
    output req, a_in, b_in, out_ready,
    input  gnt, out_valid, out_id, out_data
  );

  modport slave (
    input  req, a_in, b_in, out_ready,
    output gnt, out_valid, out_id, out_data
  );
`endif

endinterface

// File: rtl/and_unit_rr_arbiter.sv
// Round-robin arbiter sharing one registered bitwise-AND unit among NUM_REQ requesters.
// Optional feature macro: AND_ARB_OPSEL_EN (per-requester AND/OR/XOR/NAND select).
module and_unit_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  and_unit_rr_arbiter_if.slave bus
);

  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE,
    FULL
  } state_t;

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [NUM_REQ-1:0]   gnt_q;
  logic                 valid_q;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     data_q;

  logic [NUM_REQ-1:0]   elig;
  logic                 found;
  logic [IDW-1:0]       win;
  logic [IDW:0]         idx;
  logic                 cap;
  logic [IDW-1:0]       ptr_next;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     result;

  // A requester whose grant is showing this cycle is masked so it can drop req
  // without being picked a second time.
  assign elig = bus.req & ~gnt_q;

  // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NUM_REQ)) begin
        idx = idx - (IDW+1)'(NUM_REQ);
      end
      if (!found && elig[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign cap        = found && ((state == IDLE) || bus.out_ready);
  assign ptr_next   = (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
  assign win_onehot = NUM_REQ'(1) << win;
  assign op_a       = bus.a_in[win*WIDTH +: WIDTH];
  assign op_b       = bus.b_in[win*WIDTH +: WIDTH];

`ifdef AND_ARB_OPSEL_EN
  logic [1:0] op_sel;
  logic [1:0] op_q;

  assign op_sel = bus.op_in[win*2 +: 2];

  always_comb begin
    result = '0;
    case (op_sel)
      2'b00:   result = op_a & op_b;
      2'b01:   result = op_a | op_b;
      2'b10:   result = op_a ^ op_b;
      default: result = ~(op_a & op_b);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q <= 2'b00;
    end else if (cap) begin
      op_q <= op_sel;
    end
  end

  assign bus.out_op = op_q;
`else
  assign result = op_a & op_b;
`endif

  // Result slot: a new capture may replace the held result only in the same
  // edge that the consumer takes it, so nothing is ever dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
    end else if (cap) begin
      state   <= FULL;
      ptr     <= ptr_next;
      gnt_q   <= win_onehot;
      valid_q <= 1'b1;
      id_q    <= win;
      data_q  <= result;
    end else begin
      gnt_q <= '0;
      if ((state == FULL) && bus.out_ready) begin
        state   <= IDLE;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.out_id    = id_q;
  assign bus.out_data  = data_q;

endmodule
